// File: rtl/event_meter_pkg.sv
// Shared definitions for event timing instrumentation: FSM state encoding and
// a width helper so every meter sizes its counter the same way.
package event_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } meter_state_t;

    // Bits needed to hold any count from 0 up to and including max_delay.
    function automatic int cntr_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: one-cycle pulse when the input is high and was low
// on the previous clock. The history flop clears to 0 on reset.
module edge_detect (
    input  logic clk,
    input  logic anrst,
    input  logic in,
    output logic rising
);

    logic in_d1;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            in_d1 <= 1'b0;
        end else begin
            in_d1 <= in;
        end
    end

    // A level already high when reset releases reads as an edge on the first clock.
    assign rising = in & ~in_d1;

endmodule

// File: rtl/event_delay_meter.sv
// Measures cycles from a start rising edge to the next stop rising edge and
// offers the count on a valid/ready port; saturates at MAX_DELAY as a timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a start edge; stop edges ignored
// ST_COUNT | counting cycles since the start edge
// ST_HOLD  | result/timeout presented with result_valid until accepted
module event_delay_meter
    import event_meter_pkg::*;
#(
    parameter  int MAX_DELAY = 1024,
    localparam int CNTR_W    = cntr_width(MAX_DELAY)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              stop,
    output logic [CNTR_W-1:0] result,
    output logic              timeout,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam logic [CNTR_W-1:0] MAX_CNT = CNTR_W'(MAX_DELAY);

    meter_state_t      state;
    logic [CNTR_W-1:0] cnt;
    logic [CNTR_W-1:0] cnt_next;
    logic              start_rise;
    logic              stop_rise;

    edge_detect u_start_edge (
        .clk    (clk),
        .anrst  (~arst),
        .in     (start),
        .rising (start_rise)
    );

    edge_detect u_stop_edge (
        .clk    (clk),
        .anrst  (~arst),
        .in     (stop),
        .rising (stop_rise)
    );

    // In COUNT cnt stays below MAX_CNT, so the increment cannot wrap.
    assign cnt_next = cnt + CNTR_W'(1);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            result       <= '0;
            timeout      <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (stop_rise) begin
                            state        <= ST_HOLD;
                            result       <= '0;
                            timeout      <= 1'b0;
                            result_valid <= 1'b1;
                        end else begin
                            state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    cnt <= cnt_next;
                    // A stop edge on the saturating cycle still counts as a real stop.
                    if (stop_rise) begin
                        state        <= ST_HOLD;
                        result       <= cnt_next;
                        timeout      <= 1'b0;
                        result_valid <= 1'b1;
                    end else if (cnt_next == MAX_CNT) begin
                        state        <= ST_HOLD;
                        result       <= MAX_CNT;
                        timeout      <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        state        <= ST_IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_delay_meter.sv
// Directed bench for event_delay_meter: MAX_DELAY=16 instance for the main
// scenarios plus a MAX_DELAY=1 instance for the single-cycle boundary.
module tb_event_delay_meter;

    logic       clk;
    logic       arst;

    logic       start16, stop16, ready16;
    logic [4:0] result16;
    logic       timeout16, valid16, busy16;

    logic       start1, stop1, ready1;
    logic [0:0] result1;
    logic       timeout1, valid1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    event_delay_meter #(.MAX_DELAY(16)) dut16 (
        .clk          (clk),
        .arst         (arst),
        .start        (start16),
        .stop         (stop16),
        .result       (result16),
        .timeout      (timeout16),
        .result_valid (valid16),
        .result_ready (ready16),
        .busy         (busy16)
    );

    event_delay_meter #(.MAX_DELAY(1)) dut1 (
        .clk          (clk),
        .arst         (arst),
        .start        (start1),
        .stop         (stop1),
        .result       (result1),
        .timeout      (timeout1),
        .result_valid (valid1),
        .result_ready (ready1),
        .busy         (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One dut16 measurement with ready held high; stop rises n cycles after start
    // when do_stop is set, otherwise the meter must time out at 16.
    task automatic measure16(input string tag, input int n, input bit do_stop,
                             input int exp_res, input bit exp_to);
        start16 = 1'b1;
        step(1);
        chk({tag, "_busy_arm"}, busy16, 1);
        start16 = 1'b0;
        step(n - 1);
        chk({tag, "_valid_early"}, valid16, 0);
        if (do_stop) stop16 = 1'b1;
        step(1);
        chk({tag, "_valid"}, valid16, 1);
        chk({tag, "_result"}, result16, exp_res);
        chk({tag, "_timeout"}, timeout16, exp_to);
        step(1);
        chk({tag, "_valid_drop"}, valid16, 0);
        chk({tag, "_busy_drop"}, busy16, 0);
        stop16 = 1'b0;
        step(1);
    endtask

    initial begin
        arst    = 1'b1;
        start16 = 1'b0; stop16 = 1'b0; ready16 = 1'b1;
        start1  = 1'b0; stop1  = 1'b0; ready1  = 1'b1;
        step(3);
        chk("rst_result", result16, 0);
        chk("rst_timeout", timeout16, 0);
        chk("rst_valid", valid16, 0);
        chk("rst_busy", busy16, 0);
        arst = 1'b0;
        step(10);

        // delay of 7, valid for exactly one cycle with ready high
        measure16("n7", 7, 1'b1, 7, 1'b0);

        // start and stop together from idle
        start16 = 1'b1; stop16 = 1'b1;
        step(1);
        chk("same_valid", valid16, 1);
        chk("same_result", result16, 0);
        chk("same_timeout", timeout16, 0);
        step(1);
        chk("same_valid_drop", valid16, 0);
        start16 = 1'b0; stop16 = 1'b0;
        step(1);

        // lone stop edge in idle is ignored
        stop16 = 1'b1;
        step(1);
        chk("stop_only_busy", busy16, 0);
        step(3);
        chk("stop_only_valid", valid16, 0);
        stop16 = 1'b0;
        step(1);

        // saturation and the stop-on-last-cycle tie
        measure16("tmo", 16, 1'b0, 16, 1'b1);
        measure16("tie16", 16, 1'b1, 16, 1'b0);
        measure16("n1", 1, 1'b1, 1, 1'b0);

        // back-pressure with edges thrown at HOLD
        ready16 = 1'b0;
        start16 = 1'b1;
        step(1);
        start16 = 1'b0;
        step(4);
        stop16 = 1'b1;
        step(1);
        chk("bp_valid", valid16, 1);
        chk("bp_result", result16, 5);
        for (int i = 0; i < 6; i++) begin
            start16 = ~i[0];
            stop16  = ~i[0];
            step(1);
            chk("bp_hold_valid", valid16, 1);
            chk("bp_hold_result", result16, 5);
            chk("bp_hold_timeout", timeout16, 0);
        end
        ready16 = 1'b1; start16 = 1'b1; stop16 = 1'b1;
        step(1);
        chk("bp_hs_valid", valid16, 0);
        chk("bp_hs_busy", busy16, 0);
        step(3);
        chk("bp_phantom_valid", valid16, 0);
        chk("bp_phantom_busy", busy16, 0);
        start16 = 1'b0; stop16 = 1'b0;
        step(1);

        // asynchronous reset mid-count, start held through release
        start16 = 1'b1;
        step(1);
        step(3);
        chk("ar_busy_before", busy16, 1);
        chk("ar_result_before", result16, 5);
        arst = 1'b1;
        #1;
        chk("ar_busy", busy16, 0);
        chk("ar_valid", valid16, 0);
        chk("ar_result", result16, 0);
        chk("ar_timeout", timeout16, 0);
        step(2);
        arst = 1'b0;
        step(1);
        chk("ar_rearm_busy", busy16, 1);
        step(2);
        chk("ar_rearm_valid_early", valid16, 0);
        stop16 = 1'b1;
        step(1);
        chk("ar_rearm_valid", valid16, 1);
        chk("ar_rearm_result", result16, 3);
        chk("ar_rearm_timeout", timeout16, 0);
        start16 = 1'b0; stop16 = 1'b0;
        step(2);

        // MAX_DELAY=1 boundary
        start1 = 1'b1;
        step(1);
        chk("m1_busy", busy1, 1);
        stop1 = 1'b1;
        step(1);
        chk("m1_stop_valid", valid1, 1);
        chk("m1_stop_result", result1, 1);
        chk("m1_stop_timeout", timeout1, 0);
        step(1);
        chk("m1_stop_drop", valid1, 0);
        start1 = 1'b0; stop1 = 1'b0;
        step(1);
        start1 = 1'b1;
        step(1);
        chk("m1_tmo_valid_early", valid1, 0);
        step(1);
        chk("m1_tmo_valid", valid1, 1);
        chk("m1_tmo_result", result1, 1);
        chk("m1_tmo_timeout", timeout1, 1);
        start1 = 1'b0;
        step(2);
        chk("m1_idle_busy", busy1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
